// File: rtl/div_pkg.sv
// Shared types and constants for the divider front-end.
// Operand width is common with the 4-bit restoring divider.
package div_pkg;

  localparam int OPW = 4;

  localparam logic [OPW-1:0] QUOT_DZ = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    RELEASE = 3'd2,
    WAIT    = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef struct packed {
    logic [OPW-1:0] quot;
    logic [OPW-1:0] rem;
  } result_t;

  function automatic logic is_zero(
    input logic [OPW-1:0] v
  );
    return v == '0;
  endfunction

endpackage

// File: rtl/div_op_issuer_key_debounce.sv
// Pushbutton synchroniser and debouncer.
// Emits a one-cycle pulse on an accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n_i,
  output logic press_evt_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          evt_q;

  // Stability counter: restart on agreement, flip level when it saturates.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser, debounced level and press pulse registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      evt_q   <= deb_q & ~deb_d;
    end
  end

  assign press_evt_o = evt_q;

endmodule

// File: rtl/div_op_issuer.sv
// Front-end controller for the 4-bit restoring divider.
// Latches operands, sequences go, captures and holds results.
module div_op_issuer
  import div_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           key_n,
  input  logic [OPW-1:0] sw_dividend,
  input  logic [OPW-1:0] sw_divisor,
  output logic           div_go,
  output logic [OPW-1:0] div_dividend,
  output logic [OPW-1:0] div_divisor,
  input  logic [OPW-1:0] div_quotient,
  input  logic [OPW-1:0] div_remainder,
  input  logic           div_valid,
  output logic [OPW-1:0] quotient,
  output logic [OPW-1:0] remainder,
  output logic           result_ready,
  output logic           div_by_zero,
  output logic           timeout_err,
  output logic           busy
);

  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  logic           press_evt;

  state_e         state_q;
  state_e         state_d;
  logic [OPW-1:0] dvd_q;
  logic [OPW-1:0] dvd_d;
  logic [OPW-1:0] dvs_q;
  logic [OPW-1:0] dvs_d;
  result_t        res_q;
  result_t        res_d;
  logic           rr_q;
  logic           rr_d;
  logic           dz_q;
  logic           dz_d;
  logic           to_q;
  logic           to_d;
  logic           go_q;
  logic           go_d;
  logic           busy_q;
  logic           busy_d;
  logic [TCW-1:0] tcnt_q;
  logic [TCW-1:0] tcnt_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk        (clk),
    .resetn     (resetn),
    .key_n_i    (key_n),
    .press_evt_o(press_evt)
  );

  // Request sequencing: accept, issue go pulse, wait for valid or timeout.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    rr_d    = rr_q;
    dz_d    = dz_q;
    to_d    = to_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (press_evt) begin
          dvd_d = sw_dividend;
          dvs_d = sw_divisor;
          to_d  = 1'b0;
          if (is_zero(sw_divisor)) begin
            res_d.quot = QUOT_DZ;
            res_d.rem  = sw_dividend;
            dz_d       = 1'b1;
            rr_d       = 1'b1;
            state_d    = DONE;
          end else begin
            dz_d    = 1'b0;
            rr_d    = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (div_valid) begin
          res_d.quot = div_quotient;
          res_d.rem  = div_remainder;
          rr_d       = 1'b1;
          state_d    = DONE;
        end else if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
          res_d   = '0;
          to_d    = 1'b1;
          rr_d    = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered strobes derived from the next state.
  always_comb begin
    go_d   = (state_d == ISSUE);
    busy_d = (state_d == ISSUE) ||
             (state_d == RELEASE) ||
             (state_d == WAIT);
  end

  // State, operand and result registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      rr_q    <= 1'b0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      rr_q    <= rr_d;
      dz_q    <= dz_d;
      to_q    <= to_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign div_go       = go_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign quotient     = res_q.quot;
  assign remainder    = res_q.rem;
  assign result_ready = rr_q;
  assign div_by_zero  = dz_q;
  assign timeout_err  = to_q;
  assign busy         = busy_q;

endmodule

// File: doc/div_op_issuer.md
# div_op_issuer

Front-end controller for the 4-bit restoring divider on the DE1-SoC lab board. It synchronises and debounces the raw go pushbutton, then latches the switch operands and holds them stable for the divider. It issues the divider's go-high/go-low start sequence, waits for the divider's result-valid, and holds the captured quotient/remainder for the HEX/LED display. Divide-by-zero is resolved locally, and a hung divider is caught by a timeout.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: cycles the synchronised key level must be stable before it is accepted; the board build overrides it to 500000.
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before timeout_err is raised.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- key_n  in  1  raw pushbutton, active-low, asynchronous to clk.
- sw_dividend  in  4  dividend switches.
- sw_divisor  in  4  divisor switches.
- div_go  out  1  go to the divider.
- div_dividend  out  4  latched dividend to the divider.
- div_divisor  out  4  latched divisor to the divider.
- div_quotient  in  4  quotient from the divider.
- div_remainder  in  4  remainder from the divider.
- div_valid  in  1  result-valid from the divider.
- quotient  out  4  held quotient.
- remainder  out  4  held remainder.
- result_ready  out  1  quotient/remainder outputs are valid.
- div_by_zero  out  1  last request had divisor 0.
- timeout_err  out  1  last request timed out.
- busy  out  1  a request is in flight.

## Operation
Key path:
- key_n passes through a 2-FF synchroniser.
- The debounced level resets to 1 (released).
- A counter clears whenever the synchronised level equals the debounced level.
- While the levels differ the counter increments; on reaching DEBOUNCE_CYCLES-1 the debounced level takes the new value.
- press_evt is a 1-cycle pulse on a debounced 1->0 transition.

FSM states: IDLE, ISSUE, RELEASE, WAIT, DONE.
- IDLE/DONE + press_evt, divisor != 0: latch both operands, clear div_by_zero and timeout_err, drop result_ready, go to ISSUE.
- IDLE/DONE + press_evt, divisor == 0: latch operands, quotient = 4'hF, remainder = dividend, set div_by_zero, go to DONE. div_go is never asserted.
- ISSUE: div_go = 1 for exactly one cycle, then RELEASE.
- RELEASE: div_go = 0, clear the timeout counter, then WAIT. RELEASE masks the divider's stale valid from its previous DISPLAY state.
- WAIT, div_valid = 1: capture div_quotient/div_remainder, go to DONE.
- WAIT, counter == TIMEOUT_CYCLES-1 with no valid: quotient = remainder = 0, set timeout_err, go to DONE. If div_valid arrives on the same cycle as the timeout, div_valid wins.
- DONE: result_ready = 1 and results held until the next press_evt.

Busy and operand rules:
- busy = 1 in ISSUE, RELEASE and WAIT.
- press_evt while busy is dropped; it is not queued.
- div_dividend/div_divisor change only on a press_evt accept and are held constant otherwise, including through DONE.
- sw_* changes outside an accept have no effect.

Reset:
- resetn = 0 on any edge forces IDLE and clears every output to 0, the debounce counter to 0, and the debounced level to 1.
- A reset mid-request abandons it with no result. The divider shares resetn.

## Timing
- Key latency: key_n fall to press_evt is 2 + DEBOUNCE_CYCLES cycles when the key is clean.
- Request timeline, with press_evt in cycle E:
  - div_go = 1 in E+1, 0 in E+2.
  - The divider runs its 4 shift cycles in E+3..E+6.
  - div_valid in E+7; result_ready = 1 from E+8.
- Divide-by-zero: result_ready and div_by_zero are 1 from E+1.
- Timeout: timeout_err and result_ready are 1 from E+3+TIMEOUT_CYCLES.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE=0 .. DONE=4, 3 bits);
  - QUOT_DZ = 4'hF;
  - the operand width constant OPW = 4, shared with the divider.
- Sub-module key_debounce (synchroniser, debounce counter, falling-edge pulse; parameter DEBOUNCE_CYCLES) is instantiated once.
- The FSM and the result registers stay in div_op_issuer.

## Test plan
- Dividend 13, divisor 4, clean press, divider model attached -> div_go high only in E+1; quotient 3, remainder 1, result_ready at E+8; flags 0.
- Dividend 9, divisor 0 -> div_go never high; quotient F, remainder 9, div_by_zero = 1 at E+1.
- key_n glitch low for DEBOUNCE_CYCLES-2 cycles, then high -> no press_evt, state stays IDLE. A clean hold -> exactly one press_evt.
- Second press during WAIT, with switches changed to 15/2 -> ignored; result matches the first operands. A later press in DONE -> quotient 7, remainder 1.
- div_valid tied 0 -> timeout_err = 1, quotient/remainder 0, result_ready at E+19 with default parameters.
- resetn low during WAIT -> next cycle all outputs 0, state IDLE. A new press then completes normally with 6/3 -> quotient 2, remainder 0.
